mw_stage_buf: RTL and testbench

Parametrised MEM/WB pipeline stage for the CPU core, successor to the plain MEM/WB register. Carries MEM-stage results to write-back across a valid/ready handshake with a two-entry skid buffer, so WB back-pressure never combinationally reaches MEM. Supports synchronous flush and NUM_RF register-file write channels. Formats load data (byte/half/word, signed/unsigned) at the output and flags misaligned loads.

---
 rtl/mw_stage_buf_pkg.sv | 20 ++
 rtl/mw_stage_buf_if.sv | 34 +++
 rtl/mw_stage_buf_load_fmt.sv | 21 ++
 rtl/mw_stage_buf.sv | 76 +++++++
 tb/tb_mw_stage_buf.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mw_stage_buf_pkg.sv
// cpu_pkg: load funct3 encodings and the MEM/WB entry layout.
package cpu_pkg;
    localparam int MW_XLEN   = 32;
    localparam int MW_RA_W   = 5;
    localparam int MW_NUM_RF = 2;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef struct packed {
        logic [MW_XLEN-1:0]             alu_out;
        logic [MW_XLEN-1:0]             ld_data;
        logic [1:0]                     addr_lo;
        logic [MW_NUM_RF*MW_RA_W-1:0]   rd;
        logic [MW_NUM_RF-1:0]           we;
        logic [2:0]                     funct3;
        logic                           wb_sel;
    } mw_entry_t;
endpackage

// File: rtl/mw_stage_buf_if.sv
// mw_stage_buf_if: MEM-side and WB-side handshakes of the MEM/WB stage.
interface mw_stage_buf_if
    import cpu_pkg::*;
#(
    parameter int XLEN   = MW_XLEN,
    parameter int RA_W   = MW_RA_W,
    parameter int NUM_RF = MW_NUM_RF
);
    logic                   m_valid;
    logic                   m_ready;
    logic [XLEN-1:0]        m_alu_out;
    logic [XLEN-1:0]        m_ld_data;
    logic [1:0]             m_addr_lo;
    logic [NUM_RF*RA_W-1:0] m_rd;
    logic [NUM_RF-1:0]      m_we;
    logic [2:0]             m_funct3;
    logic                   m_wb_sel;
    logic                   flush;
    logic                   w_valid;
    logic                   w_ready;
    logic [XLEN-1:0]        w_wb_data;
    logic [NUM_RF*RA_W-1:0] w_rd;
    logic [NUM_RF-1:0]      w_we;
    logic                   w_misalign;
    logic [1:0]             occ;
    modport master (
        output m_valid, m_alu_out, m_ld_data, m_addr_lo, m_rd, m_we, m_funct3, m_wb_sel, flush, w_ready,
        input  m_ready, w_valid, w_wb_data, w_rd, w_we, w_misalign, occ
    );
    modport slave (
        input  m_valid, m_alu_out, m_ld_data, m_addr_lo, m_rd, m_we, m_funct3, m_wb_sel, flush, w_ready,
        output m_ready, w_valid, w_wb_data, w_rd, w_we, w_misalign, occ
    );
endinterface

// File: rtl/mw_stage_buf_load_fmt.sv
// load_fmt: extracts and extends the loaded byte/half/word and flags misalignment.
module load_fmt
    import cpu_pkg::*;
(
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lo,
    input  logic [MW_XLEN-1:0] word,
    output logic [MW_XLEN-1:0] data,
    output logic               misalign
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = 8'(word >> {addr_lo, 3'b000});
    assign h = addr_lo[1] ? word[31:16] : word[15:0];
    assign data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                  funct3 == F3_LBU ? {24'h0, b} :
                  funct3 == F3_LH  ? {{16{h[15]}}, h} :
                  funct3 == F3_LHU ? {16'h0, h} : word;
    assign misalign = ((funct3 == F3_LH || funct3 == F3_LHU) && addr_lo[0]) ||
                      (funct3 == F3_LW && addr_lo != 2'd0);
endmodule

// File: rtl/mw_stage_buf.sv
// mw_stage_buf: MEM/WB stage with a two-entry skid buffer, flush and load formatting.
// m_ready is registered so WB stalls never reach MEM combinationally.
module mw_stage_buf
    import cpu_pkg::*;
#(
    parameter int XLEN   = MW_XLEN,
    parameter int RA_W   = MW_RA_W,
    parameter int NUM_RF = MW_NUM_RF
) (
    input  logic           clk,
    input  logic           rst,
    mw_stage_buf_if.slave  io
);
    mw_entry_t         head, skid, head_n, skid_n, in_e;
    logic              head_v, skid_v, head_v_n, skid_v_n, ready_q, acc, pop, fmt_mis, mis;
    logic [XLEN-1:0]   fmt_data;
    logic [NUM_RF-1:0] we_out;
    assign in_e = '{alu_out: io.m_alu_out, ld_data: io.m_ld_data, addr_lo: io.m_addr_lo,
                    rd: io.m_rd, we: io.m_we, funct3: io.m_funct3, wb_sel: io.m_wb_sel};
    assign acc = io.m_valid & ready_q;
    assign pop = head_v & io.w_ready;
    // ready_q is low whenever the skid is full, so acc and a full skid never coincide
    always_comb begin
        head_n   = head;
        skid_n   = skid;
        head_v_n = head_v;
        skid_v_n = skid_v;
        if (io.flush) begin
            head_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (pop) begin
            head_v_n = skid_v | acc;
            head_n   = skid_v ? skid : in_e;
            skid_v_n = 1'b0;
        end else if (acc) begin
            skid_n   = head_v ? in_e : skid;
            skid_v_n = head_v;
            head_n   = head_v ? head : in_e;
            head_v_n = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            head    <= '0;
            skid    <= '0;
            head_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            head    <= head_n;
            skid    <= skid_n;
            head_v  <= head_v_n;
            skid_v  <= skid_v_n;
            ready_q <= !(head_v_n & skid_v_n);
        end
    end
    load_fmt u_fmt (
        .funct3   (head.funct3),
        .addr_lo  (head.addr_lo),
        .word     (head.ld_data),
        .data     (fmt_data),
        .misalign (fmt_mis)
    );
    assign mis = head_v & head.wb_sel & fmt_mis;
    always_comb begin
        we_out    = head.we & {NUM_RF{head_v & !mis}};
        we_out[0] = we_out[0] & (head.rd[RA_W-1:0] != '0);
    end
    assign io.m_ready    = ready_q;
    assign io.w_valid    = head_v;
    assign io.w_wb_data  = head.wb_sel ? fmt_data : head.alu_out;
    assign io.w_rd       = head.rd;
    assign io.w_we       = we_out;
    assign io.w_misalign = mis;
    assign io.occ        = {1'b0, head_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_mw_stage_buf.sv
// tb_mw_stage_buf: directed tables, corner sequences and random traffic against a queue model.
module tb_mw_stage_buf;
    import cpu_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    mw_stage_buf_if bus ();
    mw_stage_buf dut (.clk(clk), .rst(rst), .io(bus));
    typedef struct {
        logic [31:0] alu, ld;
        logic [1:0]  lo;
        logic [9:0]  rd;
        logic [1:0]  we;
        logic [2:0]  f3;
        logic        sel;
    } beat_t;
    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic        sel;
        logic [4:0]  rd0;
        logic [1:0]  we;
        logic [31:0] d;
        logic        mis;
        logic [1:0]  ewe;
    } vec_t;
    beat_t q[$];
    logic  rdy_m = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic logic [31:0] fmt_m(beat_t b);
        logic [31:0] byt, hlf;
        byt = (b.ld >> (8 * b.lo)) & 32'hff;
        hlf = (b.ld >> (16 * b.lo[1])) & 32'hffff;
        case (b.f3)
            3'd0: return byt >= 128 ? byt - 32'd256 : byt;
            3'd1: return hlf >= 32768 ? hlf - 32'd65536 : hlf;
            3'd4: return byt;
            3'd5: return hlf;
            default: return b.ld;
        endcase
    endfunction
    function automatic logic mis_m(beat_t b);
        return b.sel && (((b.f3 == 3'd1 || b.f3 == 3'd5) && b.lo[0]) || (b.f3 == 3'd2 && b.lo != 2'd0));
    endfunction
    task automatic drive(logic v, logic [31:0] alu, logic [31:0] ld, logic [1:0] lo,
                         logic [9:0] rd, logic [1:0] we, logic [2:0] f3, logic sel);
        bus.m_valid = v; bus.m_alu_out = alu; bus.m_ld_data = ld; bus.m_addr_lo = lo;
        bus.m_rd = rd; bus.m_we = we; bus.m_funct3 = f3; bus.m_wb_sel = sel;
    endtask
    task automatic cyc();
        beat_t b;
        logic acc, pop;
        b.alu = bus.m_alu_out; b.ld = bus.m_ld_data; b.lo = bus.m_addr_lo; b.rd = bus.m_rd;
        b.we = bus.m_we; b.f3 = bus.m_funct3; b.sel = bus.m_wb_sel;
        acc = bus.m_valid && rdy_m;
        pop = q.size() > 0 && bus.w_ready;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            rdy_m = 1'b0;
        end else if (bus.flush) begin
            q.delete();
            rdy_m = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(b);
            rdy_m = q.size() != 2;
        end
        #1;
    endtask
    task automatic check_all(string tag);
        logic [1:0] ewe;
        logic       em;
        chk({tag, ".valid"}, 32'(bus.w_valid), 32'(q.size() > 0));
        chk({tag, ".occ"}, 32'(bus.occ), 32'(q.size()));
        chk({tag, ".m_ready"}, 32'(bus.m_ready), 32'(rdy_m));
        if (q.size() > 0) begin
            em  = mis_m(q[0]);
            ewe = em ? 2'b00 : {q[0].we[1], q[0].we[0] && q[0].rd[4:0] != 5'd0};
            chk({tag, ".data"}, bus.w_wb_data, q[0].sel ? fmt_m(q[0]) : q[0].alu);
            chk({tag, ".rd"}, 32'(bus.w_rd), 32'(q[0].rd));
            chk({tag, ".mis"}, 32'(bus.w_misalign), 32'(em));
            chk({tag, ".we"}, 32'(bus.w_we), 32'(ewe));
        end else begin
            chk({tag, ".we_idle"}, 32'(bus.w_we), 32'd0);
            chk({tag, ".mis_idle"}, 32'(bus.w_misalign), 32'd0);
        end
    endtask
    initial begin
        vec_t tv[9];
        int   k;
        logic r;
        int   got[$];
        tv[0] = '{F3_LB,  2'd1, 1'b1, 5'd3, 2'b01, 32'hFFFFFFF2, 1'b0, 2'b01};
        tv[1] = '{F3_LBU, 2'd3, 1'b1, 5'd3, 2'b01, 32'h00000080, 1'b0, 2'b01};
        tv[2] = '{F3_LH,  2'd2, 1'b1, 5'd3, 2'b01, 32'hFFFF8081, 1'b0, 2'b01};
        tv[3] = '{F3_LHU, 2'd0, 1'b1, 5'd3, 2'b01, 32'h0000F2F3, 1'b0, 2'b01};
        tv[4] = '{F3_LH,  2'd1, 1'b1, 5'd3, 2'b01, 32'hFFFFF2F3, 1'b1, 2'b00};
        tv[5] = '{F3_LW,  2'd0, 1'b1, 5'd3, 2'b01, 32'h8081F2F3, 1'b0, 2'b01};
        tv[6] = '{F3_LW,  2'd2, 1'b1, 5'd3, 2'b11, 32'h8081F2F3, 1'b1, 2'b00};
        tv[7] = '{F3_LB,  2'd1, 1'b0, 5'd0, 2'b11, 32'h12345678, 1'b0, 2'b10};
        tv[8] = '{3'b011, 2'd1, 1'b1, 5'd3, 2'b01, 32'h8081F2F3, 1'b0, 2'b01};
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush = 0;
        bus.w_ready = 0;
        cyc();
        cyc();
        chk("rst.valid", 32'(bus.w_valid), 32'd0);
        chk("rst.occ", 32'(bus.occ), 32'd0);
        chk("rst.we", 32'(bus.w_we), 32'd0);
        chk("rst.mis", 32'(bus.w_misalign), 32'd0);
        chk("rst.data", bus.w_wb_data, 32'd0);
        chk("rst.rd", 32'(bus.w_rd), 32'd0);
        rst = 1'b1;
        cyc();
        chk("rst.m_ready", 32'(bus.m_ready), 32'd1);
        bus.w_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 32'h100 + 32'(i), 32'h0, 0, 10'(i), 2'b01, F3_LW, 0);
            cyc();
            chk("stream.valid", 32'(bus.w_valid), 32'd1);
            chk("stream.rd", 32'(bus.w_rd), 32'(i));
            chk("stream.data", bus.w_wb_data, 32'h100 + 32'(i));
            chk("stream.we", 32'(bus.w_we), 32'b01);
            chk("stream.occ", 32'(bus.occ), 32'd1);
        end
        bus.m_valid = 0;
        cyc();
        check_all("stream_end");
        bus.w_ready = 0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            drive(1, 32'h200 + 32'(k), 32'h0, 0, 10'(5 + k), 2'b01, F3_LW, 0);
            r = bus.m_ready;
            cyc();
            if (r) k++;
            check_all("bp_fill");
        end
        chk("bp.occ", 32'(bus.occ), 32'd2);
        chk("bp.m_ready", 32'(bus.m_ready), 32'd0);
        chk("bp.head_rd", 32'(bus.w_rd), 32'd5);
        chk("bp.accepted", 32'(k), 32'd2);
        bus.w_ready = 1;
        for (int c = 0; c < 6; c++) begin
            if (k < 3) drive(1, 32'h200 + 32'(k), 32'h0, 0, 10'(5 + k), 2'b01, F3_LW, 0);
            else bus.m_valid = 0;
            r = bus.m_ready;
            if (bus.w_valid && bus.w_ready) got.push_back(int'(bus.w_rd));
            cyc();
            if (r && k < 3) k++;
            check_all("bp_drain");
        end
        chk("bp.count", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("bp.order", 32'(got[i]), 32'(5 + i));
        for (int i = 0; i < 9; i++) begin
            drive(1, 32'h12345678, 32'h8081F2F3, tv[i].lo, {5'd7, tv[i].rd0}, tv[i].we, tv[i].f3, tv[i].sel);
            cyc();
            chk($sformatf("ld%0d.valid", i), 32'(bus.w_valid), 32'd1);
            chk($sformatf("ld%0d.data", i), bus.w_wb_data, tv[i].d);
            chk($sformatf("ld%0d.mis", i), 32'(bus.w_misalign), 32'(tv[i].mis));
            chk($sformatf("ld%0d.we", i), 32'(bus.w_we), 32'(tv[i].ewe));
            bus.m_valid = 0;
            cyc();
        end
        bus.w_ready = 0;
        drive(1, 32'h300, 0, 0, 10'd8, 2'b01, F3_LW, 0);
        cyc();
        cyc();
        chk("fl.occ_full", 32'(bus.occ), 32'd2);
        drive(1, 32'h3FF, 0, 0, 10'd9, 2'b01, F3_LW, 0);
        bus.flush = 1;
        cyc();
        chk("fl.occ", 32'(bus.occ), 32'd0);
        chk("fl.valid", 32'(bus.w_valid), 32'd0);
        drive(1, 32'h301, 0, 0, 10'd10, 2'b01, F3_LW, 0);
        bus.flush = 0;
        cyc();
        drive(1, 32'h3FE, 0, 0, 10'd11, 2'b01, F3_LW, 0);
        bus.flush = 1;
        cyc();
        bus.flush = 0;
        bus.m_valid = 0;
        chk("fl1.occ", 32'(bus.occ), 32'd0);
        cyc();
        chk("fl1.valid", 32'(bus.w_valid), 32'd0);
        check_all("fl_after");
        for (int c = 0; c < 500; c++) begin
            logic [9:0] rd;
            rd = 10'($urandom);
            if ($urandom_range(0, 3) == 0) rd[4:0] = 5'd0;
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)), rd,
                  2'($urandom), 3'($urandom), 1'($urandom));
            bus.w_ready = $urandom_range(0, 2) != 0;
            bus.flush = $urandom_range(0, 24) == 0;
            rst = $urandom_range(0, 59) != 0;
            cyc();
            check_all("rnd");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
